// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and default width for the sequential multiplier
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SEQ_MULT_WIDTH = 32;

endpackage

// File: rtl/seq_mult_negate.sv
// rtl/seq_mult_negate.sv - conditional two's-complement negate
module seq_mult_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] result
);

    assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/seq_mult_ctl.sv
// rtl/seq_mult_ctl.sv - shift-add multiplier with start/busy/done handshake; SEQ_MULT_EARLY_TERM_EN enables early exit
module seq_mult_ctl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW = 2 * WIDTH;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     neg_product;
    logic [WIDTH-1:0]  mplier;
    logic [WIDTH-1:0]  abs1;
    logic [WIDTH-1:0]  abs2;
    logic              neg;
    logic              sign1;
    logic              sign2;
    logic              accept;
    logic              finish;

    assign sign1 = signed_mode & op1[WIDTH-1];
    assign sign2 = signed_mode & op2[WIDTH-1];

    seq_mult_negate #(.W(WIDTH)) u_abs1 (
        .en     (sign1),
        .value  (op1),
        .result (abs1)
    );

    seq_mult_negate #(.W(WIDTH)) u_abs2 (
        .en     (sign2),
        .value  (op2),
        .result (abs2)
    );

    seq_mult_negate #(.W(PW)) u_neg_product (
        .en     (neg),
        .value  (acc),
        .result (neg_product)
    );

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign finish = (mplier == '0);
`else
    localparam int             CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  STEPS = CW'(WIDTH);

    // Fixed-latency build: always WIDTH steps, so timing is operand-independent
    logic [CW-1:0] step_cnt;

    assign finish = (step_cnt == STEPS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (accept) begin
            step_cnt <= '0;
        end else if (state == RUN && !finish) begin
            step_cnt <= step_cnt + CW'(1);
        end
    end
`endif

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (finish) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                accept     = start;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, abs1};
            mplier <= abs2;
            neg    <= sign1 ^ sign2;
        end else if (state == RUN) begin
            if (finish) begin
                product <= neg_product;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_mult_ctl.sv
// tb/tb_seq_mult_ctl.sv - directed self-checking bench for seq_mult_ctl
module tb_seq_mult_ctl;

    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic            signed_mode = 1'b0;
    logic [W-1:0]    op1 = '0;
    logic [W-1:0]    op2 = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int checks = 0;
    int failures = 0;

    seq_mult_ctl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .op1         (op1),
        .op2         (op2),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
`ifdef SEQ_MULT_EARLY_TERM_EN
        return k + 1;
`else
        return W + 1;
`endif
    endfunction

    // Called #1 after an edge; raises start for exactly one sampling edge (E0)
    task automatic start_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        signed_mode = sm;
        op1 = a;
        op2 = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Called #1 after E0; counts edges until done and busy cycles along the way
    task automatic wait_done(input string tag, input logic [63:0] exp, input int lat_exp);
        int lat;
        int nbusy;
        lat = 0;
        nbusy = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) nbusy++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, "_busy_cycles"}, 64'(nbusy), 64'(lat_exp));
        chk({tag, "_product"}, product, exp);
    endtask

    task automatic run_op(input string tag, input logic sm, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp, input int k);
        start_op(sm, a, b);
        wait_done(tag, exp, exp_lat(k));
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hold"}, product, exp);
    endtask

    initial begin
        rst = 1'b1;
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", product, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("u3x5",      1'b0, 32'd3,          32'd5,          64'd15,                  3);
        run_op("s_m7x6",    1'b1, 32'hFFFF_FFF9,  32'd6,          64'hFFFF_FFFF_FFFF_FFD6, 3);
        run_op("s_min_sq",  1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000, 32);
        run_op("s_m1x0",    1'b1, 32'hFFFF_FFFF,  32'd0,          64'd0,                   0);
        run_op("u_max_sq",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 32);
        run_op("s_m1xm1",   1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1,                   1);
        run_op("u_msbx2",   1'b0, 32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000, 2);
        run_op("s_5xm3",    1'b1, 32'd5,          32'hFFFF_FFFD,  64'hFFFF_FFFF_FFFF_FFF1, 2);

        // start and operands changed during RUN are ignored; held start is taken at DONE
        start_op(1'b0, 32'd11, 32'd13);
        start = 1'b1;
        signed_mode = 1'b0;
        op1 = 32'd99;
        op2 = 32'd77;
        wait_done("ign_first", 64'd143, exp_lat(4));
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", 64'd7623, exp_lat(7));
        @(posedge clk);
        #1;
        chk("b2b_done_pulse", 64'(done), 64'd0);

        // reset mid-RUN discards the operation and clears the product
        start_op(1'b0, 32'd200, 32'd255);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_product", product, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("u9x9", 1'b0, 32'd9, 32'd9, 64'd81, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
